// File: rtl/tmp_pkg.sv
// Shared types and constants for the temperature readout slice.
//   state_t     : readout FSM states (IDLE / ACQ / HOLD)
//   CNT_W       : width of the sink/source pulse counters
//   CODE_W      : width of the signed result code
//   TMO_CYC_DEF : default maximum ACQ length in cycles
//   diff_code() : zero-extend both counts and subtract (two's complement)
package tmp_pkg;

    localparam int CNT_W       = 10;
    localparam int CODE_W      = 12;
    localparam int TMO_CYC_DEF = 4095;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_HOLD
    } state_t;

    function automatic logic [CODE_W-1:0] diff_code(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        return {{(CODE_W-CNT_W){1'b0}}, a} - {{(CODE_W-CNT_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/tmp_readout_if.sv
// Result handshake between the readout block and its consumer.
//   code       : signed result (snk_cnt - src_cnt)
//   code_valid : result-holding flag
//   code_ready : consumer accept
// master = readout block, slave = consumer.
interface tmp_readout_if;
    import tmp_pkg::*;

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);

endinterface

// File: rtl/tmp_sat_cnt.sv
// Clearable, enabled up-counter that saturates at all-ones instead of wrapping.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count enable
//   cnt_o      : current count
module tmp_sat_cnt
    import tmp_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmp_readout.sv
// Charge-balance temperature sensor readout. A PII2 rising edge opens a frame;
// during ACQ, sink and source pulses (qualified by PI2) are counted. Once the
// H and L phase patterns have both been seen, the rising edge of the end
// marker (PA&PB&PC&PD) latches code = snk_cnt - src_cnt. A frame that runs
// TMO_CYC ACQ cycles without a valid end is abandoned with a timeout pulse.
//   clk, reset         : clock, synchronous active-high reset
//   PII2, PI2, PA..PD  : switch-phase controls from the sensor controller
//   snk, src_n         : sink pulse (1) / source pulse (0)
//   out                : result handshake (code, code_valid, code_ready)
//   busy               : frame in progress (ACQ or HOLD)
//   overrun            : sticky, a result was dropped while one was pending
//   timeout            : one-cycle pulse when ACQ is abandoned
module tmp_readout
    import tmp_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PII2,
    input  logic          PI2,
    input  logic          PA,
    input  logic          PB,
    input  logic          PC,
    input  logic          PD,
    input  logic          snk,
    input  logic          src_n,
    tmp_readout_if.master out,
    output logic          busy,
    output logic          overrun,
    output logic          timeout
);

    localparam int TMR_W = $clog2(TMO_CYC + 1);

    state_t             state_q;
    logic               pii2_q, mark_q;
    logic               h_seen_q, l_seen_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CODE_W-1:0]  code_q;
    logic               valid_q, overrun_q, timeout_q;
    logic [CNT_W-1:0]   snk_cnt, src_cnt;

    logic frame_start, marker, marker_rise, is_h, is_l, in_acq;

    assign frame_start = PII2 & ~pii2_q;
    assign marker      = PA & PB & PC & PD;
    assign marker_rise = marker & ~mark_q;
    assign is_h        = PA & PB & ~PC & ~PD;
    assign is_l        = PA & PC & ~PB & ~PD;
    assign in_acq      = (state_q == S_ACQ);

    // Clear takes priority inside the counter, so a restart in ACQ never counts.
    tmp_sat_cnt #(.W(CNT_W)) u_snk_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (frame_start),
        .en_i  (in_acq & PI2 & snk),
        .cnt_o (snk_cnt)
    );

    tmp_sat_cnt #(.W(CNT_W)) u_src_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (frame_start),
        .en_i  (in_acq & PI2 & ~src_n),
        .cnt_o (src_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pii2_q    <= 1'b0;
            mark_q    <= 1'b0;
            h_seen_q  <= 1'b0;
            l_seen_q  <= 1'b0;
            tmr_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pii2_q    <= PII2;
            mark_q    <= marker;
            timeout_q <= 1'b0;

            // Consumer accept; a same-cycle latch below re-asserts valid.
            if (valid_q && out.code_ready)
                valid_q <= 1'b0;

            if (frame_start) begin
                state_q  <= S_ACQ;
                h_seen_q <= 1'b0;
                l_seen_q <= 1'b0;
                tmr_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_ACQ: begin
                        if (is_h) h_seen_q <= 1'b1;
                        if (is_l) l_seen_q <= 1'b1;
                        if (marker_rise && h_seen_q && l_seen_q) begin
                            state_q <= S_HOLD;
                            // Pending result not being taken: keep it, drop the new one.
                            if (!valid_q || out.code_ready) begin
                                code_q  <= diff_code(snk_cnt, src_cnt);
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else if (tmr_q == TMR_W'(TMO_CYC - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!marker)
                            state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out.code       = code_q;
    assign out.code_valid = valid_q;
    assign busy           = (state_q != S_IDLE);
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_tmp_readout.sv
// Self-checking bench for tmp_readout: expected codes are pushed to a
// scoreboard queue as each frame is driven and popped when the DUT presents
// its result. Inputs change on the falling edge; outputs are sampled there.
module tb_tmp_readout;
    import tmp_pkg::*;

    logic clk = 1'b0;
    logic reset, PII2, PI2, PA, PB, PC, PD, snk, src_n;
    logic busy, overrun, timeout;

    tmp_readout_if bus();

    int total = 0;
    int bad   = 0;
    logic [CODE_W-1:0] sb[$];
    logic [CODE_W-1:0] exp_code;
    logic [CODE_W-1:0] held_code;

    always #5 clk = ~clk;

    tmp_readout #(.TMO_CYC(TMO_CYC_DEF)) dut (
        .clk     (clk),
        .reset   (reset),
        .PII2    (PII2),
        .PI2     (PI2),
        .PA      (PA),
        .PB      (PB),
        .PC      (PC),
        .PD      (PD),
        .snk     (snk),
        .src_n   (src_n),
        .out     (bus),
        .busy    (busy),
        .overrun (overrun),
        .timeout (timeout)
    );

    // Reference: saturate each count at 1023, then 12-bit two's complement difference.
    function automatic logic [CODE_W-1:0] model(input int a, input int b);
        int sa = (a > 1023) ? 1023 : a;
        int sb_ = (b > 1023) ? 1023 : b;
        return CODE_W'(sa - sb_);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_phase(input logic a, input logic b, input logic c, input logic d);
        PA = a; PB = b; PC = c; PD = d;
    endtask

    task automatic idle_inputs();
        PII2 = 1'b0; PI2 = 1'b0; snk = 1'b0; src_n = 1'b1;
        set_phase(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_frame();
        PII2 = 1'b1;
        tick();
        PII2 = 1'b0;
    endtask

    task automatic pump(input int n_snk, input int n_src);
        int n = (n_snk > n_src) ? n_snk : n_src;
        for (int i = 0; i < n; i++) begin
            PI2   = 1'b1;
            snk   = (i < n_snk);
            src_n = !(i < n_src);
            tick();
        end
        PI2 = 1'b0; snk = 1'b0; src_n = 1'b1;
    endtask

    task automatic send_h();
        set_phase(1'b1, 1'b1, 1'b0, 1'b0); tick(); set_phase(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_l();
        set_phase(1'b1, 1'b0, 1'b1, 1'b0); tick(); set_phase(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_marker();
        set_phase(1'b1, 1'b1, 1'b1, 1'b1); tick();
    endtask

    task automatic drop_marker();
        set_phase(1'b0, 1'b0, 1'b0, 1'b0); tick();
    endtask

    task automatic consume();
        bus.code_ready = 1'b1; tick(); bus.code_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.code_ready = 1'b0;
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        total++; if (bus.code !== '0) begin bad++; $display("FAIL rst_code: got %0h expected 0", bus.code); end
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", bus.code_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_basic();
        start_frame(); pump(40, 15); send_h(); send_l();
        sb.push_back(model(40, 15));
        send_marker();
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b expected 1", bus.code_valid); end
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL basic_code: got %0h expected %0h", bus.code, exp_code); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_hold: got %b expected 1", busy); end
        drop_marker();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
        consume();
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL basic_consume: got %b expected 0", bus.code_valid); end
    endtask

    task automatic test_saturation();
        start_frame(); pump(1100, 0); send_h(); send_l();
        sb.push_back(model(1100, 0));
        send_marker();
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b expected 1", bus.code_valid); end
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL sat_code: got %0h expected %0h", bus.code, exp_code); end
        drop_marker(); consume();
    endtask

    task automatic test_early_marker();
        start_frame(); pump(10, 3); send_h();
        send_marker();
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL early_no_latch: got %b expected 0", bus.code_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL early_still_acq: got %b expected 1", busy); end
        drop_marker(); send_l();
        sb.push_back(model(10, 3));
        send_marker();
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL early_latch_valid: got %b expected 1", bus.code_valid); end
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL early_latch_code: got %0h expected %0h", bus.code, exp_code); end
        drop_marker(); consume();
        send_marker(); drop_marker();
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL early_single_latch: got %b expected 0", bus.code_valid); end
    endtask

    task automatic test_back_to_back();
        // Second result arrives while the first is pending and not accepted.
        start_frame(); pump(5, 2); send_h(); send_l();
        sb.push_back(model(5, 2));
        send_marker(); drop_marker();
        start_frame(); pump(2, 6); send_h(); send_l(); send_marker(); drop_marker();
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b expected 1", bus.code_valid); end
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL b2b_kept_code: got %0h expected %0h", bus.code, exp_code); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        consume();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun_sticky: got %b expected 1", overrun); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun_reset: got %b expected 0", overrun); end

        // Same again, but the consumer accepts on the second latch cycle.
        start_frame(); pump(8, 1); send_h(); send_l();
        sb.push_back(model(8, 1));
        send_marker(); drop_marker();
        start_frame(); pump(1, 9); send_h(); send_l();
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL b2b_first_code: got %0h expected %0h", bus.code, exp_code); end
        sb.push_back(model(1, 9));
        bus.code_ready = 1'b1; send_marker(); bus.code_ready = 1'b0;
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL b2b_ready_valid: got %b expected 1", bus.code_valid); end
        exp_code = sb.pop_front();
        held_code = exp_code;
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL b2b_ready_code: got %0h expected %0h", bus.code, exp_code); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ready_overrun: got %b expected 0", overrun); end
        drop_marker();
    endtask

    task automatic test_timeout();
        int  n    = 0;
        logic seen = 1'b0;
        start_frame();
        while (!seen && n < 5000) begin
            tick(); n++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        total++; if (!seen || n != TMO_CYC_DEF) begin bad++; $display("FAIL tmo_cycles: got %0d (seen=%b) expected %0d", n, seen, TMO_CYC_DEF); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b expected 0", busy); end
        total++; if (bus.code_valid !== 1'b1) begin bad++; $display("FAIL tmo_valid: got %b expected 1", bus.code_valid); end
        total++; if (bus.code !== held_code) begin bad++; $display("FAIL tmo_code: got %0h expected %0h", bus.code, held_code); end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse_len: got %b expected 0", timeout); end
    endtask

    task automatic test_priority();
        consume();
        start_frame(); pump(20, 5); send_h(); send_l();
        // Marker rise and a new PII2 edge together: the restart must win.
        set_phase(1'b1, 1'b1, 1'b1, 1'b1); PII2 = 1'b1; tick(); PII2 = 1'b0;
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL prio_no_latch: got %b expected 0", bus.code_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy: got %b expected 1", busy); end
        drop_marker(); pump(6, 9); send_h(); send_l();
        sb.push_back(model(6, 9));
        send_marker();
        exp_code = sb.pop_front();
        total++; if (bus.code !== exp_code) begin bad++; $display("FAIL prio_code: got %0h expected %0h", bus.code, exp_code); end
        drop_marker(); consume();
    endtask

    task automatic test_reset_mid();
        start_frame(); pump(12, 4); send_h(); send_l();
        reset = 1'b1; tick(); reset = 1'b0;
        send_marker(); drop_marker();
        total++; if (bus.code_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b expected 0", bus.code_valid); end
        total++; if (bus.code !== '0) begin bad++; $display("FAIL rmid_code: got %0h expected 0", bus.code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmid_overrun: got %b expected 0", overrun); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rmid_timeout: got %b expected 0", timeout); end
    endtask

    initial begin
        reset = 1'b1;
        bus.code_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_saturation();
        test_early_marker();
        test_back_to_back();
        test_timeout();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tmp_readout.md
TMP_READOUT -- requirements
Module: tmp_readout

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs PII2, PI2, PA, PB, PC, PD  1 bit each: switch-phase controls from the sensor controller, sampled as data.
REQ-004 SHALL have inputs snk (1 = sink pulse) and src_n (0 = source pulse)  1 bit each: charge-balance pulses from the sensor controller.
REQ-005 SHALL have output code  12  signed result, snk_cnt minus src_cnt.
REQ-006 SHALL have output code_valid  1  result-holding flag; input code_ready  1  consumer accept.
REQ-007 SHALL have outputs busy  1  (frame in progress), overrun  1  (sticky), timeout  1  (one-cycle pulse).
REQ-008 SHALL have parameter TMO_CYC, default 4095: maximum ACQ length in cycles.

Function
REQ-009 SHALL run a state machine with states IDLE, ACQ, HOLD.
REQ-010 SHALL detect frame start as a PII2 0->1 edge (registered previous value); in any state this clears snk_cnt, src_cnt, h_seen, l_seen and the cycle timer, and enters ACQ.
REQ-011 In ACQ, SHALL increment snk_cnt on each cycle where PI2=1 and snk=1.
REQ-012 In ACQ, SHALL increment src_cnt on each cycle where PI2=1 and src_n=0.
REQ-013 SHALL keep both counters 10 bits wide, saturating at 1023 (no wrap).
REQ-014 In ACQ, SHALL set h_seen when PA&PB&!PC&!PD, and set l_seen when PA&PC&!PB&!PD.
REQ-015 SHALL treat the end marker as PA&PB&PC&PD.
REQ-016 SHALL act on an end marker in ACQ only on its first cycle (rising edge of the marker), and only when h_seen and l_seen are both set.
  - Action: latch code = zero-extended snk_cnt minus zero-extended src_cnt (12-bit two's complement); enter HOLD.
REQ-017 SHALL ignore an end marker in ACQ while h_seen or l_seen is clear, and stay in ACQ.
REQ-018 In HOLD, SHALL return to IDLE on the first cycle the marker is absent; counters frozen.
REQ-019 SHALL set code_valid on the cycle after a latch and clear it on a cycle with code_valid&code_ready.
REQ-020 On a latch while code_valid=1 and code_ready=0, SHALL keep the old code, drop the new one and set overrun.
REQ-021 On a latch while code_valid=1 and code_ready=1, SHALL load the new code and keep code_valid=1 (no overrun).
REQ-022 SHALL count ACQ cycles; on reaching TMO_CYC it SHALL pulse timeout for one cycle and return to IDLE, with code/code_valid untouched.
REQ-023 SHALL clear overrun only by reset.
REQ-024 SHALL drive busy=1 exactly in ACQ and HOLD.
REQ-025 SHALL give PII2 edge priority over the end marker and over timeout when they occur in the same cycle.

Reset
REQ-026 On reset=1, SHALL go to IDLE next cycle, with code=0, code_valid=0, busy=0, overrun=0, timeout=0, counters=0, h_seen/l_seen=0 and previous-value registers=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no latch SHALL occur until a new PII2 edge.

Structure
REQ-028 Package tmp_pkg SHALL hold the state enum, CNT_W=10, CODE_W=12, and the TMO_CYC default.
REQ-029 SHALL instantiate sub-module tmp_sat_cnt (clear, enable, saturating counter) twice: snk and src.

Verification
REQ-030 Reset, PII2 edge, 40 snk cycles and 15 src cycles under PI2=1, H then L pattern, marker -> code=25, code_valid=1, no overrun.
REQ-031 1100 snk cycles and 0 src cycles, full frame -> code=1023 (saturation).
REQ-032 Marker before L pattern -> no latch; then L, then marker -> latch once.
REQ-033 Two frames with code_ready=0 -> first code kept, overrun=1; repeat with code_ready=1 at second latch -> second code, no overrun.
REQ-034 PII2 edge then no marker for 4095 cycles -> timeout pulse, busy=0, code_valid unchanged.
REQ-035 Reset asserted mid-ACQ, then marker -> no latch; all outputs 0.
